// File: rtl/spi_rom_pkg.sv
// Shared types and helpers for the SPI line fetcher: FSM encoding, default
// read opcode and counter/pointer width helpers.
package spi_rom_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StCmd  = 2'd1;
  localparam state_t StAddr = 2'd2;
  localparam state_t StData = 2'd3;

  localparam logic [7:0] DefaultCmd = 8'h03;

  // Wide enough to count the longest phase (opcode, address or data).
  function automatic int unsigned cnt_width(int unsigned addr_w, int unsigned buf_bits);
    int unsigned m;
    m = 8;
    if (addr_w > m) m = addr_w;
    if (buf_bits > m) m = buf_bits;
    return $clog2(m);
  endfunction

  function automatic int unsigned ptr_width(int unsigned buf_bits);
    return (buf_bits > 1) ? $clog2(buf_bits) : 1;
  endfunction

endpackage

// File: rtl/spi_line_fetcher_if.sv
// Host handshake, read-port and SPI pin bundle of the line fetcher.
interface spi_line_fetcher_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              abort;
  logic              busy;
  logic              done;
  logic              swap;
  logic              rd_shift;
  logic              rd_rewind;
  logic              rd_bit;
  logic              spi_cs;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;

  modport master (
    output start, addr, abort, swap, rd_shift, rd_rewind, spi_miso,
    input  busy, done, rd_bit, spi_cs, spi_sclk, spi_mosi
  );

  modport slave (
    input  start, addr, abort, swap, rd_shift, rd_rewind, spi_miso,
    output busy, done, rd_bit, spi_cs, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_pingpong_buf.sv
// Front/back bit buffers: the fetch fills the back buffer while the reader walks
// the front one; a swap exchanges them and rewinds the read pointer.
module spi_pingpong_buf import spi_rom_pkg::*; #(
  parameter int unsigned BUF_BITS = 128,
  parameter int unsigned IDX_W    = ptr_width(BUF_BITS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             busy,
  input  logic             fetch_end,
  input  logic             swap,
  input  logic             rd_shift,
  input  logic             rd_rewind,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_bit,
  output logic             rd_bit
);

  logic [BUF_BITS-1:0] buf0_q, buf1_q;
  logic [BUF_BITS-1:0] front;
  logic                sel_q, sel_d;
  logic                pend_q, pend_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                swap_exec;

  // A swap requested mid-fetch is held until the edge that ends the fetch.
  assign swap_exec = (swap && !busy) || (fetch_end && (swap || pend_q));
  assign front     = sel_q ? buf1_q : buf0_q;
  assign rd_bit    = front[ptr_q];

  always_comb begin
    sel_d  = sel_q;
    pend_d = pend_q;
    ptr_d  = ptr_q;
    if (swap_exec) begin
      sel_d  = ~sel_q;
      pend_d = 1'b0;
      ptr_d  = '0;
    end else begin
      if (swap && busy) pend_d = 1'b1;
      if (rd_rewind) begin
        ptr_d = '0;
      end else if (rd_shift) begin
        ptr_d = (ptr_q == IDX_W'(BUF_BITS - 1)) ? '0 : ptr_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf0_q <= '0;
      buf1_q <= '0;
      sel_q  <= 1'b0;
      pend_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      if (wr_en) begin
        if (sel_q) buf0_q[wr_idx] <= wr_bit;
        else       buf1_q[wr_idx] <= wr_bit;
      end
      sel_q  <= sel_d;
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule

// File: rtl/spi_line_fetcher.sv
// SPI read-command sequencer: sends opcode and address, shifts BUF_BITS of data
// into the back buffer of a ping-pong pair and pulses done on completion.
module spi_line_fetcher import spi_rom_pkg::*; #(
  parameter int unsigned BUF_BITS = 128,
  parameter int unsigned ADDR_W   = 24,
  parameter logic [7:0]  CMD      = DefaultCmd
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_line_fetcher_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(ADDR_W, BUF_BITS);
  localparam int unsigned PtrW = ptr_width(BUF_BITS);
  localparam int unsigned ShW  = 8 + ADDR_W;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ShW-1:0]  sh_q, sh_d;
  logic            cs_q, cs_d;
  logic            done_q, done_d;
  logic            miso_q;
  logic            fetch_end;
  logic            wr_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    cs_d      = cs_q;
    done_d    = 1'b0;
    fetch_end = 1'b0;
    if ((state_q != StIdle) && bus.abort) begin
      state_d   = StIdle;
      cnt_d     = '0;
      sh_d      = '0;
      cs_d      = 1'b0;
      fetch_end = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCmd: begin
          sh_d = {sh_q[ShW-2:0], 1'b0};
          if (cnt_q == CntW'(7)) begin
            state_d = StAddr;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StAddr: begin
          // Zero-fill leaves the shifter clear, so MOSI idles low in DATA.
          sh_d = {sh_q[ShW-2:0], 1'b0};
          if (cnt_q == CntW'(ADDR_W - 1)) begin
            state_d = StData;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntW'(BUF_BITS - 1)) begin
            state_d   = StIdle;
            cnt_d     = '0;
            cs_d      = 1'b0;
            done_d    = 1'b1;
            fetch_end = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      endcase
      // Also taken on the completion edge, chaining transfers with CS held high.
      if ((state_d == StIdle) && bus.start && !bus.abort) begin
        state_d = StCmd;
        cnt_d   = '0;
        sh_d    = {CMD, bus.addr};
        cs_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sh_q    <= '0;
      cs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
    end
  end

  // MISO is captured mid-cycle; the bit lands in the buffer on the next rising edge.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) miso_q <= 1'b0;
    else          miso_q <= bus.spi_miso;
  end

  assign wr_en        = (state_q == StData);
  assign bus.spi_sclk = ~clk;
  assign bus.spi_cs   = cs_q;
  assign bus.busy     = cs_q;
  assign bus.done     = done_q;
  assign bus.spi_mosi = sh_q[ShW-1];

  spi_pingpong_buf #(
    .BUF_BITS (BUF_BITS),
    .IDX_W    (PtrW)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .busy      (cs_q),
    .fetch_end (fetch_end),
    .swap      (bus.swap),
    .rd_shift  (bus.rd_shift),
    .rd_rewind (bus.rd_rewind),
    .wr_en     (wr_en),
    .wr_idx    (cnt_q[PtrW-1:0]),
    .wr_bit    (miso_q),
    .rd_bit    (bus.rd_bit)
  );

endmodule
